// File: rtl/sram_pkg.sv
// Shared widths, controller state encoding and response record for the SRAM
// request controller.
package sram_pkg;

   localparam int unsigned SRAM_AW = 12;
   localparam int unsigned SRAM_DW = 64;
   localparam int unsigned SRAM_MW = 8;

   typedef enum logic {
      S_IDLE,
      S_RMW_WR
   } ctrl_state_e;

   typedef struct packed {
      logic               write;
      logic [SRAM_DW-1:0] rdata;
   } rsp_t;

   // Byte lane select: masked lanes take new data, the rest keep the old word.
   function automatic logic [SRAM_DW-1:0] byte_merge(
      input logic [SRAM_DW-1:0] new_data,
      input logic [SRAM_DW-1:0] old_data,
      input logic [SRAM_MW-1:0] mask
   );
      logic [SRAM_DW-1:0] merged;
      merged = old_data;
      for (int unsigned i = 0; i < SRAM_MW; i++) begin
         if (mask[i]) merged[8*i +: 8] = new_data[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO; head entry and valid come straight from state
// registers. Push and pop may coincide, including when full.
module sram_rsp_fifo
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = rsp_t
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  T                           push_data,
   input  logic                       pop,
   output T                           pop_data,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      do_pop  = pop && (cnt != '0);
      do_push = push && ((cnt != FULL) || do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign valid    = (cnt != '0);
   assign count    = cnt;

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready command front-end for the 4K x 64 SRAM macro: reads, full
// writes, byte-masked writes via read-modify-write, in-order responses.
module sram_req_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_read,
   input  logic [SRAM_AW-1:0] cmd_addr,
   input  logic [SRAM_DW-1:0] cmd_wdata,
   input  logic [SRAM_MW-1:0] cmd_wmask,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_write,
   output logic [SRAM_DW-1:0] rsp_rdata,
   output logic               sram_csbn,
   output logic               sram_wsbn,
   output logic [SRAM_AW-1:0] sram_waddr,
   output logic [SRAM_DW-1:0] sram_wdata,
   output logic [SRAM_AW-1:0] sram_raddr,
   input  logic [SRAM_DW-1:0] sram_rdata
);

   localparam int unsigned CW      = $clog2(RSP_DEPTH);
   localparam logic [CW:0] DEPTH_L = RSP_DEPTH[CW:0];

   ctrl_state_e        state;
   logic [SRAM_AW-1:0] rmw_addr;
   logic [SRAM_DW-1:0] rmw_wdata;
   logic [SRAM_MW-1:0] rmw_mask;
   logic               inflight_valid;
   logic               inflight_write;
   logic [SRAM_AW-1:0] raddr_q;
   logic [SRAM_AW-1:0] waddr_q;
   logic [SRAM_DW-1:0] wdata_q;
   logic [CW:0]        fifo_count;
   logic [CW:0]        credit_used;
   logic               accept;
   logic               mask_full;
   logic               mask_zero;
   rsp_t               push_rsp;
   rsp_t               head_rsp;

   // The inflight slot is counted as occupied so its unconditional push always fits.
   always_comb begin
      credit_used = fifo_count + {{CW{1'b0}}, inflight_valid};
      cmd_ready   = rst_n && (state == S_IDLE) && (credit_used < DEPTH_L);
      accept      = cmd_valid && cmd_ready;
      mask_full   = &cmd_wmask;
      mask_zero   = ~|cmd_wmask;
   end

   always_comb begin
      sram_csbn  = 1'b1;
      sram_wsbn  = 1'b1;
      sram_raddr = raddr_q;
      sram_waddr = waddr_q;
      sram_wdata = wdata_q;
      if (rst_n) begin
         if (state == S_RMW_WR) begin
            sram_csbn  = 1'b0;
            sram_wsbn  = 1'b0;
            sram_waddr = rmw_addr;
            sram_wdata = byte_merge(rmw_wdata, sram_rdata, rmw_mask);
         end else if (accept) begin
            if (cmd_read || !mask_full) begin
               if (!mask_zero || cmd_read) begin
                  sram_csbn  = 1'b0;
                  sram_raddr = cmd_addr;
               end
            end else begin
               sram_csbn  = 1'b0;
               sram_wsbn  = 1'b0;
               sram_waddr = cmd_addr;
               sram_wdata = cmd_wdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         rmw_addr       <= '0;
         rmw_wdata      <= '0;
         rmw_mask       <= '0;
         inflight_valid <= 1'b0;
         inflight_write <= 1'b0;
         raddr_q        <= '0;
         waddr_q        <= '0;
         wdata_q        <= '0;
      end else begin
         inflight_valid <= 1'b0;
         inflight_write <= 1'b0;
         raddr_q        <= sram_raddr;
         waddr_q        <= sram_waddr;
         wdata_q        <= sram_wdata;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (cmd_read) begin
                     inflight_valid <= 1'b1;
                  end else if (mask_full || mask_zero) begin
                     inflight_valid <= 1'b1;
                     inflight_write <= 1'b1;
                  end else begin
                     rmw_addr  <= cmd_addr;
                     rmw_wdata <= cmd_wdata;
                     rmw_mask  <= cmd_wmask;
                     state     <= S_RMW_WR;
                  end
               end
            end
            S_RMW_WR: begin
               inflight_valid <= 1'b1;
               inflight_write <= 1'b1;
               state          <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      push_rsp.write = inflight_write;
      push_rsp.rdata = inflight_write ? '0 : sram_rdata;
   end

   sram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .T     (rsp_t)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_valid),
      .push_data (push_rsp),
      .pop       (rsp_ready),
      .pop_data  (head_rsp),
      .valid     (rsp_valid),
      .count     (fifo_count)
   );

   assign rsp_write = head_rsp.write;
   assign rsp_rdata = head_rsp.rdata;

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request-side controller that sits directly upstream of the 4K x 64-bit SRAM macro and turns a valid/ready command stream into the macro's active-low chip-select/write-select port protocol. It adds byte-masked writes, implemented as read-modify-write because the macro has no byte enables, and returns one in-order response per command through a small response FIFO so the consumer can apply backpressure. Throughput is one read or full-word write per cycle.

## Interface
- `RSP_DEPTH`, default 4: response FIFO entries; minimum 2; must be a power of two.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_read` in 1: 1 = read, 0 = write.
- `cmd_addr` in 12: word address.
- `cmd_wdata` in 64: write data.
- `cmd_wmask` in 8: byte enables; bit i covers bits [8i+7:8i].
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_write` out 1: 1 = response to a write.
- `rsp_rdata` out 64: read data; 0 for write responses.
- `sram_csbn` out 1: macro chip select, active low.
- `sram_wsbn` out 1: macro write select, active low.
- `sram_waddr` out 12: macro write address.
- `sram_wdata` out 64: macro write data.
- `sram_raddr` out 12: macro read address.
- `sram_rdata` in 64: macro registered read data, valid the cycle after a read access.

## Operation
- States: `S_IDLE`, `S_RMW_WR`.
- `cmd_ready = rst_n && state==S_IDLE && (fifo_count + inflight_valid < RSP_DEPTH)`. It is low whenever `rst_n` is low.
- Control outputs `sram_csbn` and `sram_wsbn` are combinational from the handshake and state. They are never low while `rst_n` is low.
- At most one SRAM access per cycle, so there are no same-cycle read/write hazards.
- Accepted commands in `S_IDLE`:
  - Read: `csbn=0`, `wsbn=1`, `raddr=cmd_addr`.
  - Write, mask 8'hFF: `csbn=0`, `wsbn=0`, `waddr=cmd_addr`, `wdata=cmd_wdata`.
  - Write, mask 8'h00: no access (`csbn=1`); a response is still produced.
  - Write, partial mask: read access to `cmd_addr`; latch addr/wdata/mask; go to `S_RMW_WR`.
- `S_RMW_WR`, for exactly one cycle:
  - `csbn=0`, `wsbn=0`, `waddr` = latched addr.
  - `wdata` byte i = `mask[i] ? latched wdata byte i : sram_rdata byte i`.
  - Set the inflight register; return to `S_IDLE`.
- Inflight register: holds a 1-bit valid and a type for the access made in the previous cycle.
  - It pushes into the FIFO unconditionally the following cycle. The credit check guarantees space.
  - For a read, the push captures `sram_rdata`; for a write it pushes data 0.
  - A partial write does not load the inflight register on its read access, only on the `S_RMW_WR` access.
- FIFO: push and pop in the same cycle are allowed when it is full or empty. Responses leave in command order.
- `sram_raddr` and `sram_waddr` hold their last driven value when idle. No requirement applies to them when `csbn=1`.

## Timing
- Reset values: `state=S_IDLE`; FIFO empty; inflight clear; `rsp_valid=0`; `rsp_write=0`; `rsp_rdata=0`; `cmd_ready=0` while in reset; `sram_csbn=1`; `sram_wsbn=1`.
- Latencies, with handshake in cycle N:
  - Read, full write and zero-mask write: `rsp_valid` earliest in N+2.
  - Partial write: `rsp_valid` earliest in N+3, and `cmd_ready=0` in N+1.
- Steady-state throughput with `rsp_ready=1` and the default depth: 1 command/cycle.
- Backpressure: `cmd_ready` drops once `fifo_count + inflight = RSP_DEPTH`. It returns the cycle after a pop frees space.
- Reset mid-operation: async reset in `S_RMW_WR` aborts the write; the memory keeps its old word. The FIFO and inflight register are discarded.

## Structure
- Package `sram_pkg` holds:
  - `SRAM_AW=12`, `SRAM_DW=64`, `SRAM_MW=8`;
  - the state enum `ctrl_state_e`;
  - the response struct `{write, rdata}`.
- One sub-module, `sram_rsp_fifo`: a synchronous FIFO with registered outputs, parameterised on depth and the response struct, exposing a count.

## Test plan
- Reset: with `rst_n=0` and `cmd_valid=1`, require `cmd_ready=0`, `sram_csbn=1`, `sram_wsbn=1`, `rsp_valid=0`. After release, `cmd_ready=1`.
- Write 0x123 with data 64'hDEAD_BEEF_0123_4567 and mask FF, then read 0x123 on the next cycle: two write-then-read responses in order; `rsp_rdata` = 64'hDEAD_BEEF_0123_4567; read response 2 cycles after its handshake.
- Pre-load 0x040 with 64'hAAAA_AAAA_AAAA_AAAA, then write data 64'h1111_1111_2222_2222 with mask 8'h0F: `cmd_ready` low for 1 cycle. A subsequent read returns 64'hAAAA_AAAA_2222_2222.
- Write with mask 8'h00 to 0x010: `sram_csbn` stays 1; a write response is returned; a later read returns the prior contents.
- With `rsp_ready=0`, offer 6 back-to-back reads: exactly 4 are accepted and `cmd_ready` stays 0. Then raise `rsp_ready`: all 6 responses arrive in address order with correct data.
- Assert `rst_n=0` during `S_RMW_WR` of a mask 8'hF0 write to 0x020: no write occurs; a read after reset returns the original word.
